// File: rtl/sr_dmem_arbiter.sv
// sr_dmem_arbiter
// Two-master arbiter for the single data-memory port.
// m0 is the CPU data port and m1 is the loader/debug master.
// At most one access is granted per cycle, and the grant is combinational.
// Read responses are steered back to their issuer through a {valid, id}
// delay line that is READ_LAT stages deep, so the returned data lines up
// with mem_rdata.
module sr_dmem_arbiter #(
  parameter int READ_LAT = 1,  // memory read latency, 1..4
  parameter int ARB_MODE = 0   // 0 = round-robin, 1 = fixed priority (m0 wins)
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [1:0]  m0_size,
  input  logic        m0_sign,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [1:0]  m1_size,
  input  logic        m1_sign,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,

  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_sign,
  input  logic [31:0] mem_rdata
);

  // Out-of-range latencies are clamped so the delay line always has legal bounds.
  localparam int LAT = (READ_LAT < 1) ? 1 : ((READ_LAT > 4) ? 4 : READ_LAT);

  // One access request, bundled so that the mux indexes by master id.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        sign;
  } acc_t;

  acc_t        acc [2];
  logic [1:0]  req_v;
  logic [1:0]  gnt_v;
  logic [1:0]  rvalid_v;
  logic        gnt_id;
  logic        any_gnt;

  // Last-granted master. It resets to 1 so that m0 wins the first tie.
  logic        ptr_q, ptr_d;

  // Response delay line. Stage LAT-1 lines up with mem_rdata.
  logic [LAT-1:0] vld_q, vld_d;
  logic [LAT-1:0] id_q,  id_d;

  logic        rsp_valid;
  logic        rsp_id;

  assign acc[0] = {m0_we, m0_addr, m0_wdata, m0_size, m0_sign};
  assign acc[1] = {m1_we, m1_addr, m1_wdata, m1_size, m1_sign};
  assign req_v  = {m1_req, m0_req};

  // Pick the winner for this cycle. Nothing is granted while reset is asserted.
  always_comb begin
    gnt_v  = 2'b00;
    gnt_id = 1'b0;
    if (!rst) begin
      unique case (req_v)
        2'b01: begin
          gnt_v  = 2'b01;
          gnt_id = 1'b0;
        end
        2'b10: begin
          gnt_v  = 2'b10;
          gnt_id = 1'b1;
        end
        2'b11: begin
          if (ARB_MODE == 1) begin
            gnt_id = 1'b0;
          end else begin
            gnt_id = ~ptr_q;
          end
          gnt_v = gnt_id ? 2'b10 : 2'b01;
        end
        default: begin
          gnt_v  = 2'b00;
          gnt_id = 1'b0;
        end
      endcase
    end
  end

  assign any_gnt = |gnt_v;

  // Drive the memory port from the granted master, and hold it at zero when idle.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_size  = 2'b00;
    mem_sign  = 1'b0;
    if (any_gnt) begin
      mem_req   = 1'b1;
      mem_we    = acc[gnt_id].we;
      mem_addr  = acc[gnt_id].addr;
      mem_wdata = acc[gnt_id].wdata;
      mem_size  = acc[gnt_id].size;
      mem_sign  = acc[gnt_id].sign;
    end
  end

  // The round-robin pointer follows the most recent grant.
  always_comb begin
    ptr_d = ptr_q;
    if (any_gnt) begin
      ptr_d = gnt_id;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= 1'b1;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Stage 0 records granted reads. Later stages shift every cycle.
  always_comb begin
    vld_d    = '0;
    id_d     = '0;
    vld_d[0] = mem_req & ~mem_we;
    id_d[0]  = gnt_id;
    for (int i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      id_d[i]  = id_q[i-1];
    end
  end

  // Response delay-line registers. Reset drops every read that is in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      id_q  <= '0;
    end else begin
      vld_q <= vld_d;
      id_q  <= id_d;
    end
  end

  assign rsp_valid = vld_q[LAT-1];
  assign rsp_id    = id_q[LAT-1];

  // Per-master grant and response-valid steering.
  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    assign rvalid_v[gi] = rsp_valid & (rsp_id == gi[0]);
  end

  assign m0_gnt    = gnt_v[0];
  assign m1_gnt    = gnt_v[1];
  assign m0_rvalid = rvalid_v[0];
  assign m1_rvalid = rvalid_v[1];
  assign m0_rdata  = rvalid_v[0] ? mem_rdata : 32'h0;
  assign m1_rdata  = rvalid_v[1] ? mem_rdata : 32'h0;

endmodule
